// File: rtl/v810_pkg.sv
// Shared types and constants for the V810 exception-entry sequencer:
// PSW layout, system-register indices, FSM states and the PSW entry update.
package v810_pkg;

    // PSW bit layout, MSB first: [19:16] I, 15 NP, 14 EP, 13 AE, 12 ID, [9:0] flags
    typedef struct packed {
        logic [11:0] rsv_hi;
        logic [3:0]  i;
        logic        np;
        logic        ep;
        logic        ae;
        logic        id;
        logic [1:0]  rsv_mid;
        logic [9:0]  flags;
    } psw_t;

    localparam logic [4:0] SR_EIPC  = 5'd0;
    localparam logic [4:0] SR_EIPSW = 5'd1;
    localparam logic [4:0] SR_FEPC  = 5'd2;
    localparam logic [4:0] SR_FEPSW = 5'd3;
    localparam logic [4:0] SR_ECR   = 5'd4;
    localparam logic [4:0] SR_PSW   = 5'd5;

    localparam logic [31:0] PSW_RESET_VAL = 32'h0000_8000;
    localparam logic [15:0] CC_RESET      = 16'hFFF0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAPT     = 3'd1,
        S_SAVE_PC  = 3'd2,
        S_SAVE_PSW = 3'd3,
        S_SAVE_ECR = 3'd4,
        S_SET_PSW  = 3'd5,
        S_JUMP     = 3'd6,
        S_HALT     = 3'd7
    } exc_seq_state_t;

    // PSW as seen by the handler: FE entries raise NP, EI entries raise EP and
    // optionally adopt the new interrupt level.
    function automatic psw_t psw_entry(psw_t p, logic np, logic [3:0] iel);
        psw_t r;
        r    = p;
        r.id = 1'b1;
        r.ae = 1'b0;
        if (np) begin
            r.np = 1'b1;
        end else begin
            r.ep = 1'b1;
            if (iel != 4'd0) begin
                r.i = iel;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/v810_exc_seq.sv
// V810 exception-entry sequencer: acknowledge, capture, save state, set PSW, redirect fetch.
// Optional fatal-exception halt is built when V810_FATAL_HALT_EN is defined.
module v810_exc_seq
    import v810_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_res,
    input  logic           i_ce,
    input  logic           i_if,
    input  logic           i_np,
    input  logic [3:0]     i_iel,
    input  logic [15:0]    i_cc,
    input  logic [31:0]    i_ha,
    output logic           o_ack,
    input  logic           i_boundary,
    input  logic [31:0]    i_pc_in,
    input  psw_t           i_psw,
    input  logic [31:0]    i_ecr_in,
    output logic           o_busy,
    output logic           o_sr_we,
    output logic [4:0]     o_sr_wa,
    output logic [31:0]    o_sr_wd,
    output logic           o_redirect,
    output logic [31:0]    o_redirect_pc,
    output logic           o_halted,
    output exc_seq_state_t o_dbg_state
);

    exc_seq_state_t r_state;
    exc_seq_state_t w_state_nxt;

    logic [31:0] r_pc_s;
    psw_t        r_psw_s;
    logic        r_np;
    logic [3:0]  r_iel;
    logic [15:0] r_cc;
    logic [31:0] r_ha;

    logic        r_ack;
    logic        r_busy;
    logic        r_sr_we;
    logic [4:0]  r_sr_wa;
    logic [31:0] r_sr_wd;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_halted;

    logic        w_take;
    logic        w_rst_cc;
    logic        w_fatal;
    logic        w_rst_case;
    psw_t        w_psw_new;

    logic        w_ack;
    logic        w_busy;
    logic        w_sr_we;
    logic [4:0]  w_sr_wa;
    logic [31:0] w_sr_wd;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_halted;

    // The multiplexer needs one cycle to drop IF after ACK, so never accept twice in a row.
    assign w_take     = (r_state == S_IDLE) && i_if && i_boundary && !r_ack;
    assign w_rst_cc   = (i_cc == CC_RESET);
    assign w_fatal    = r_psw_s.np && !w_rst_cc;
    assign w_rst_case = (r_cc == CC_RESET);
    assign w_psw_new  = psw_entry(r_psw_s, r_np, r_iel);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_take) w_state_nxt = S_CAPT;
            S_CAPT: begin
                if (w_rst_cc) begin
                    w_state_nxt = S_SAVE_ECR;
`ifdef V810_FATAL_HALT_EN
                end else if (w_fatal) begin
                    w_state_nxt = S_HALT;
`endif
                end else begin
                    w_state_nxt = S_SAVE_PC;
                end
            end
            S_SAVE_PC:  w_state_nxt = S_SAVE_PSW;
            S_SAVE_PSW: w_state_nxt = S_SAVE_ECR;
            S_SAVE_ECR: w_state_nxt = S_SET_PSW;
            S_SET_PSW:  w_state_nxt = S_JUMP;
            S_JUMP:     w_state_nxt = S_IDLE;
            S_HALT:     w_state_nxt = S_HALT;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the current state; the flops present it one cycle later.
    always_comb begin
        w_ack         = w_take;
        w_busy        = w_take || (r_state != S_IDLE);
        w_sr_we       = 1'b0;
        w_sr_wa       = r_sr_wa;
        w_sr_wd       = r_sr_wd;
        w_redirect    = 1'b0;
        w_redirect_pc = r_redirect_pc;
`ifdef V810_FATAL_HALT_EN
        w_halted      = (r_state == S_HALT);
`else
        w_halted      = 1'b0;
`endif
        case (r_state)
            S_SAVE_PC: begin
                w_sr_we = 1'b1;
                w_sr_wa = r_np ? SR_FEPC : SR_EIPC;
                w_sr_wd = r_pc_s;
            end
            S_SAVE_PSW: begin
                w_sr_we = 1'b1;
                w_sr_wa = r_np ? SR_FEPSW : SR_EIPSW;
                w_sr_wd = r_psw_s;
            end
            S_SAVE_ECR: begin
                w_sr_we = 1'b1;
                w_sr_wa = SR_ECR;
                if (w_rst_case) begin
                    w_sr_wd = {16'h0000, CC_RESET};
                end else if (r_np) begin
                    w_sr_wd = {r_cc, i_ecr_in[15:0]};
                end else begin
                    w_sr_wd = {i_ecr_in[31:16], r_cc};
                end
            end
            S_SET_PSW: begin
                w_sr_we = 1'b1;
                w_sr_wa = SR_PSW;
                w_sr_wd = w_rst_case ? PSW_RESET_VAL : w_psw_new;
            end
            S_JUMP: begin
                w_redirect    = 1'b1;
                w_redirect_pc = r_ha;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state       <= S_IDLE;
            r_pc_s        <= '0;
            r_psw_s       <= '0;
            r_np          <= 1'b0;
            r_iel         <= '0;
            r_cc          <= '0;
            r_ha          <= '0;
            r_ack         <= 1'b0;
            r_busy        <= 1'b0;
            r_sr_we       <= 1'b0;
            r_sr_wa       <= '0;
            r_sr_wd       <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_halted      <= 1'b0;
        end else if (i_ce) begin
            r_state       <= w_state_nxt;
            r_ack         <= w_ack;
            r_busy        <= w_busy;
            r_sr_we       <= w_sr_we;
            r_sr_wa       <= w_sr_wa;
            r_sr_wd       <= w_sr_wd;
            r_redirect    <= w_redirect;
            r_redirect_pc <= w_redirect_pc;
            r_halted      <= w_halted;
            if (w_take) begin
                r_pc_s  <= i_pc_in;
                r_psw_s <= i_psw;
            end
            // A fatal entry without the halt option still goes down the FE path.
            if (r_state == S_CAPT) begin
                r_np  <= i_np || w_fatal;
                r_iel <= i_iel;
                r_cc  <= i_cc;
                r_ha  <= i_ha;
            end
        end
    end

    assign o_ack         = r_ack;
    assign o_busy        = r_busy;
    assign o_sr_we       = r_sr_we;
    assign o_sr_wa       = r_sr_wa;
    assign o_sr_wd       = r_sr_wd;
    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;
    assign o_halted      = r_halted;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_v810_exc_seq.sv
// Bench for v810_exc_seq: vector table of exception entries, write/redirect
// scoreboard, plus reset, boundary, fatal-halt and clock-enable sequences.
module tb_v810_exc_seq;
    import v810_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           res = 1'b1;
    logic           ce = 1'b1;
    logic           if_req = 1'b0;
    logic           np = 1'b0;
    logic [3:0]     iel = '0;
    logic [15:0]    cc = '0;
    logic [31:0]    ha = '0;
    logic           boundary = 1'b0;
    logic [31:0]    pc_in = '0;
    logic [31:0]    psw_in = '0;
    logic [31:0]    ecr_in = '0;
    logic           o_ack, o_busy, o_sr_we, o_redirect, o_halted;
    logic [4:0]     o_sr_wa;
    logic [31:0]    o_sr_wd, o_redirect_pc;
    exc_seq_state_t o_dbg_state;

    v810_exc_seq dut (
        .i_clk(clk), .i_res(res), .i_ce(ce), .i_if(if_req), .i_np(np),
        .i_iel(iel), .i_cc(cc), .i_ha(ha), .o_ack(o_ack),
        .i_boundary(boundary), .i_pc_in(pc_in), .i_psw(psw_t'(psw_in)),
        .i_ecr_in(ecr_in), .o_busy(o_busy), .o_sr_we(o_sr_we),
        .o_sr_wa(o_sr_wa), .o_sr_wd(o_sr_wd), .o_redirect(o_redirect),
        .o_redirect_pc(o_redirect_pc), .o_halted(o_halted),
        .o_dbg_state(o_dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];
    logic [31:0] redir_q[$];

    typedef struct {
        logic        np;
        logic [3:0]  iel;
        logic [15:0] cc;
        logic [31:0] ha;
        logic [31:0] psw;
        logic [31:0] pc;
        logic [31:0] ecr;
        int          redir_cyc;
    } vec_t;

    vec_t vecs[9];

    // Scoreboard monitor: only edges taken with CE=1 and without reset count.
    logic ce_q = 1'b0;
    logic res_q = 1'b1;
    logic ack_prev = 1'b0;
    always @(posedge clk) begin
        ce_q  <= ce;
        res_q <= res;
    end

    always @(negedge clk) begin
        if (ce_q && !res_q) begin
            if (o_sr_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sr_write: unexpected wa=%0d wd=%h", o_sr_wa, o_sr_wd);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    if ({o_sr_wa, o_sr_wd} !== e) begin
                        errors++;
                        $display("FAIL sr_write: got wa=%0d wd=%h expected wa=%0d wd=%h",
                                 o_sr_wa, o_sr_wd, e[36:32], e[31:0]);
                    end
                end
            end
            if (o_redirect) begin
                checks++;
                if (redir_q.size() == 0) begin
                    errors++;
                    $display("FAIL redirect: unexpected pc=%h", o_redirect_pc);
                end else begin
                    logic [31:0] r;
                    r = redir_q.pop_front();
                    if (o_redirect_pc !== r) begin
                        errors++;
                        $display("FAIL redirect: got pc=%h expected %h", o_redirect_pc, r);
                    end
                end
            end
            if (o_ack) begin
                checks++;
                if (ack_prev) begin
                    errors++;
                    $display("FAIL ack_back_to_back: ack high on two consecutive cycles");
                end
            end
            ack_prev = o_ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_w(input logic [4:0] wa, input logic [31:0] wd);
        exp_q.push_back({wa, wd});
    endtask

    // Reference model of the register writes for one entry.
    task automatic push_exp(input vec_t v);
        logic        fe;
        logic [31:0] p;
        fe = v.np || (v.psw[15] && v.cc != 16'hFFF0);
        if (v.cc == 16'hFFF0) begin
            push_w(5'd4, 32'h0000FFF0);
            push_w(5'd5, 32'h00008000);
        end else begin
            push_w(fe ? 5'd2 : 5'd0, v.pc);
            push_w(fe ? 5'd3 : 5'd1, v.psw);
            push_w(5'd4, fe ? {v.cc, v.ecr[15:0]} : {v.ecr[31:16], v.cc});
            p = (v.psw | 32'h0000_1000) & ~32'h0000_2000;
            if (fe) begin
                p = p | 32'h0000_8000;
            end else begin
                p = p | 32'h0000_4000;
                if (v.iel != 4'd0) p[19:16] = v.iel;
            end
            push_w(5'd5, p);
        end
        redir_q.push_back(v.ha);
    endtask

    task automatic drive_req(input vec_t v);
        @(negedge clk);
        if_req = 1'b1; boundary = 1'b1;
        np = v.np; iel = v.iel; cc = v.cc; ha = v.ha;
        psw_in = v.psw; pc_in = v.pc; ecr_in = v.ecr;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  t0, tr;
        logic done;
        t0 = -1; tr = -1; done = 1'b0;
        push_exp(v);
        drive_req(v);
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (o_ack && t0 < 0) begin
                t0 = n;
                if_req = 1'b0;
                boundary = 1'($urandom_range(0, 1));
                pc_in = $urandom;
                psw_in = $urandom;
            end
            if (t0 >= 0 && n == t0 + 1) begin
                cc = 16'($urandom); ha = $urandom;
                np = 1'($urandom_range(0, 1)); iel = 4'($urandom_range(0, 15));
            end
            if (o_redirect && tr < 0) tr = n;
            if (tr >= 0 && !o_busy) done = 1'b1;
        end
        check($sformatf("vec%0d_redirect_latency", idx), 64'(tr - t0), 64'(v.redir_cyc));
        check($sformatf("vec%0d_done_and_drained", idx),
              {done, 31'(exp_q.size()), 32'(redir_q.size())}, {1'b1, 63'd0});
        boundary = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'd6, 16'hFE50, 32'hFFFFFE50, 32'h0, 32'h07000100, 32'h12340000, 6};
        vecs[1] = '{1'b1, 4'd0, 16'hFFD0, 32'hFFFFFFD0, 32'h00052005, 32'h07000200, 32'h0000FE50, 6};
        vecs[2] = '{1'b1, 4'd0, 16'hFFF0, 32'hFFFFFFF0, 32'h0, 32'h07000300, 32'hABCD1234, 4};
        vecs[3] = '{1'b0, 4'd0, 16'hFE40, 32'hFFFFFE40, 32'h000A0000, 32'h07000400, 32'h5555AAAA, 6};
        vecs[4] = '{1'b0, 4'd9, 16'hFFF0, 32'hFFFFFFF0, 32'h00072000, 32'h07000500, 32'h0, 4};
        for (int i = 5; i < 9; i++) begin
            vecs[i].np = 1'($urandom_range(0, 1));
            vecs[i].iel = 4'($urandom_range(0, 15));
            vecs[i].cc = 16'($urandom_range(0, 32'hFFEF));
            vecs[i].ha = $urandom;
            vecs[i].psw = $urandom & 32'hFFFF7FFF;
            vecs[i].pc = $urandom;
            vecs[i].ecr = $urandom;
            vecs[i].redir_cyc = 6;
        end

        // Reset, then idle with no request.
        repeat (3) @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs",
                  {o_ack, o_busy, o_sr_we, o_sr_wa, o_redirect, o_halted, 3'(o_dbg_state)}, 64'd0);
        end
        check("reset_data_regs", {o_sr_wd, o_redirect_pc}, 64'd0);

        // Request without an instruction boundary must be ignored.
        @(negedge clk);
        if_req = 1'b1; boundary = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_boundary_no_ack", {o_ack, o_busy}, 64'd0);
        end
        if_req = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Exception taken while already in an NP handler.
        begin
            vec_t fv;
            fv = '{1'b0, 4'd3, 16'hFFC0, 32'hFFFFFFC0, 32'h00008000, 32'h07000600, 32'h11112222, 6};
`ifdef V810_FATAL_HALT_EN
            begin
                int t0;
                t0 = -1;
                drive_req(fv);
                for (int n = 0; n < 12; n++) begin
                    @(negedge clk);
                    if (o_ack && t0 < 0) begin
                        t0 = n; if_req = 1'b0;
                    end
                end
                check("fatal_acked", 64'(t0 >= 0), 64'd1);
                check("fatal_halted", {o_halted, o_busy, o_sr_we, o_redirect, o_ack}, 64'b11000);
                @(negedge clk);
                res = 1'b1;
                @(negedge clk);
                res = 1'b0;
                check("fatal_cleared_by_res", {o_halted, o_busy}, 64'd0);
            end
`else
            run_vec(9, fv);
`endif
        end

        // Clock-enable freeze in SAVE_PSW, then reset while SET_PSW is pending.
        begin
            vec_t cv;
            logic froze, hit;
            cv = '{1'b0, 4'd2, 16'hFE10, 32'hFFFFFE10, 32'h0, 32'h07000700, 32'h9ABC0000, 6};
            froze = 1'b0; hit = 1'b0;
            push_w(5'd0, 32'h07000700);
            push_w(5'd1, 32'h00000000);
            push_w(5'd4, 32'h9ABCFE10);
            drive_req(cv);
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (o_ack) if_req = 1'b0;
                if (o_sr_we && o_sr_wa == 5'd4) begin
                    res = 1'b1; hit = 1'b1;
                    break;
                end
                if (o_sr_we && o_sr_wa == 5'd1 && !froze) begin
                    ce = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        check("ce_freeze", {o_sr_we, o_sr_wa, o_busy, o_redirect, 3'(o_dbg_state)},
                              {1'b1, 5'd1, 1'b1, 1'b0, 3'(S_SAVE_ECR)});
                    end
                    ce = 1'b1; froze = 1'b1;
                end
            end
            check("ce_seq_reached_ecr", {froze, hit}, 64'b11);
            @(negedge clk);
            res = 1'b0;
            check("mid_seq_reset",
                  {o_ack, o_busy, o_sr_we, o_redirect, o_halted, 3'(o_dbg_state)}, 64'd0);
            repeat (6) @(negedge clk);
            check("no_psw_after_reset", {32'(exp_q.size()), 31'd0, o_busy}, 64'd0);
        end

        check("queues_empty", {32'(exp_q.size()), 32'(redir_q.size())}, 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/v810_exc_seq.md
# v810_exc_seq

Exception-entry sequencer for the V810 core. It sits between the interrupt/exception multiplexer and the execution unit. At an instruction boundary it acknowledges a pending interrupt or exception and captures the registered code, handler address, NP and level. It then writes the save registers, ECR and PSW through the system-register write port and redirects fetch to the handler. While the sequence runs it stalls the pipeline with BUSY.

## Interface
- No parameters.
- CLK  in  1  core clock
- RES  in  1  reset, synchronous, active-high
- CE  in  1  global clock enable; all state advances only when CE=1
- IF  in  1  interrupt/exception pending (from multiplexer)
- NP  in  1  registered: NMI/reset/duplexed class
- IEL  in  4  registered: new PSW.I for maskable interrupts, 0 otherwise
- CC  in  16  registered exception code
- HA  in  32  registered handler address
- ACK  out  1  one-cycle acknowledge to multiplexer
- BOUNDARY  in  1  EU at instruction boundary, safe to take exception
- PC_IN  in  32  restart PC to save
- PSW  in  psw_t  current PSW
- ECR_IN  in  32  current ECR, for preserving the other half
- BUSY  out  1  sequence in progress; EU and fetch stall
- SR_WE  out  1  system-register write strobe
- SR_WA  out  5  system-register index
- SR_WD  out  32  write data
- REDIRECT  out  1  one-cycle fetch redirect pulse
- REDIRECT_PC  out  32  redirect target
- HALTED  out  1  fatal-exception halt (see Configuration)

## Operation
- States: IDLE, CAPT, SAVE_PC, SAVE_PSW, SAVE_ECR, SET_PSW, JUMP, HALT.
- IDLE: when IF=1 and BOUNDARY=1 and ACK was not asserted in the previous cycle:
  - ACK=1 for one cycle.
  - Snapshot PC_IN to pc_s and PSW to psw_s.
  - Go to CAPT.
- CAPT: NP, IEL, CC and HA are now valid; latch them.
  - Reset case (CC=16'hFFF0): go to SAVE_ECR.
  - Fatal case (psw_s.np=1 and CC≠FFF0) with macro enabled: go to HALT.
  - Otherwise: go to SAVE_PC.
- Path selection: NP=1 uses FE registers; NP=0 uses EI registers.
- SAVE_PC: write pc_s to FEPC (2) or EIPC (0).
- SAVE_PSW: write psw_s to FEPSW (3) or EIPSW (1).
- SAVE_ECR: write ECR (4).
  - NP=1: SR_WD = {CC, ECR_IN[15:0]}.
  - NP=0: SR_WD = {ECR_IN[31:16], CC}.
  - Reset case: SR_WD = 32'h0000FFF0.
- SET_PSW: write PSW (5) from psw_s.
  - NP=1: np=1, id=1, ae=0.
  - NP=0: ep=1, id=1, ae=0; i=IEL if IEL≠0.
  - Reset case: PSW = 32'h00008000.
- JUMP: REDIRECT=1, REDIRECT_PC=HA; go to IDLE.
- HALT: BUSY=1 and HALTED=1 until RES. No writes, no ACK.
- BUSY=1 in every state except IDLE.
- SR_WE=1 only in SAVE_PC, SAVE_PSW, SAVE_ECR and SET_PSW.

## Timing
- All registered outputs reset to 0: ACK, BUSY, SR_WE, SR_WA, SR_WD, REDIRECT, REDIRECT_PC, HALTED. State resets to IDLE.
- RES mid-sequence: the next edge returns to IDLE. No further SR_WE or REDIRECT; partial writes already made stand.
- Normal sequence: ACK at cycle 0, CAPT 1, writes at 2–5, REDIRECT at 6, IDLE at 7.
- Reset sequence: ACK 0, CAPT 1, ECR 2, PSW 3, REDIRECT 4.
- ACK is never asserted in consecutive cycles. The multiplexer needs one cycle to clear its flag.
- IF or BOUNDARY changing after ACK has no effect on the running sequence.
- CE=0 freezes state and all registered outputs. Pulses (ACK, REDIRECT, SR_WE) are qualified so each fires on exactly one CE=1 cycle.
- IF=1 with BOUNDARY=0: stay IDLE, no ACK.

## Configuration
- Macro V810_FATAL_HALT_EN.
  - Defined: an exception taken while psw_s.np=1 (not reset) enters HALT and asserts HALTED.
  - Undefined: HALT is unreachable and HALTED is tied 0. The same case runs the normal FE path, overwriting FEPC/FEPSW.

## Structure
- v810_pkg holds:
  - System-register index constants: EIPC, EIPSW, FEPC, FEPSW, ECR, PSW.
  - The exc_seq_state_t enum.
  - Reset constants 32'h00008000 and 16'hFFF0.
  - A function psw_entry(psw_t, np, iel) returning the updated psw_t.
- No sub-module; PSW generation is the package function.

## Test plan
- Reset, then IF=0 for 10 cycles → all outputs 0, BUSY=0.
- IF=1, NP=0, IEL=6, CC=FE50, HA=FFFFFE50, PSW=0, PC_IN=07000100 → writes in order:
  - EIPC=07000100
  - EIPSW=0
  - ECR={ECR_IN[31:16], FE50}
  - PSW with ep=1, id=1, i=6
  - then REDIRECT_PC=FFFFFE50 at cycle 6.
- NP=1, CC=FFD0, ECR_IN=0000FE50 → writes:
  - FEPC, FEPSW
  - ECR=FFD0FE50
  - PSW with np=1, id=1
  - then REDIRECT to FFFFFFD0.
- CC=FFF0 → only ECR=0000FFF0 and PSW=00008000 written; REDIRECT to FFFFFFF0 at cycle 4.
- PSW.np=1, CC=FFC0:
  - Macro defined → HALTED=1, no SR_WE until RES.
  - Macro undefined → FEPC/FEPSW written.
- CE=0 for 3 cycles during SAVE_PSW, then RES during SET_PSW → sequence holds, then IDLE; PSW never written.
